// File: rtl/ahb_lite_slave_mux.sv
// Purpose: AHB-Lite address decoder, data-phase response mux and built-in ERROR default slave with an error log.
// Latency: decode is combinational; response/data arrive in the data phase after the accepted address phase (1 cycle, 2 for ERROR).
// Backpressure: HREADY follows the slave owning the data phase; the default slave inserts one wait state for its two-cycle ERROR.
module ahb_lite_slave_mux #(
  parameter int NUM_SLAVES = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SLOT_BITS  = 10,
  parameter int ERRCNT_W   = 8
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic [ADDR_WIDTH-1:0]          HADDR,
  input  logic [1:0]                     HTRANS,
  input  logic                           HWRITE,
  output logic [NUM_SLAVES-1:0]          HSEL_S,
  input  logic [NUM_SLAVES-1:0]          HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]          HRESP_S,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
  output logic                           HREADY,
  output logic                           HRESP,
  output logic [DATA_WIDTH-1:0]          HRDATA,
  output logic [ERRCNT_W-1:0]            err_count,
  output logic [ADDR_WIDTH-1:0]          err_addr,
  output logic                           err_write
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {D_IDLE, D_ERR1, D_ERR2} dstate_t;

  logic [ADDR_WIDTH-1:0] addr_idx;
  logic                  mapped;
  logic                  err_start;
  logic                  unused_trans_lsb;

  logic                  dsel_valid;
  logic                  dsel_dflt;
  logic [IDX_W-1:0]      dsel_idx;

  dstate_t               dstate;
  logic                  dflt_rdy;
  logic                  dflt_resp;

  logic                  slv_rdy;
  logic                  slv_resp;
  logic [DATA_WIDTH-1:0] slv_data;

  // Full-width slot index so that addresses above the last slave never alias back onto it.
  assign addr_idx         = HADDR >> SLOT_BITS;
  assign mapped           = (addr_idx < ADDR_WIDTH'(NUM_SLAVES));
  assign err_start        = HREADY & HTRANS[1] & ~mapped;
  // Only NONSEQ vs. SEQ differs in bit 0; both are treated as real transfers.
  assign unused_trans_lsb = HTRANS[0];

  // Address-phase one-hot select, independent of HTRANS.
  always_comb begin
    HSEL_S = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (mapped && (addr_idx == ADDR_WIDTH'(i))) HSEL_S[i] = 1'b1;
    end
  end

  // Data-phase owner register; advances only when the current data phase completes.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dsel_valid <= 1'b0;
      dsel_dflt  <= 1'b0;
      dsel_idx   <= '0;
    end else if (HREADY) begin
      dsel_valid <= HTRANS[1];
      dsel_dflt  <= HTRANS[1] & ~mapped;
      dsel_idx   <= addr_idx[IDX_W-1:0];
    end
  end

  // Default slave: two-cycle ERROR, back-to-back capable from D_ERR2, plus error log.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dstate    <= D_IDLE;
      dflt_rdy  <= 1'b1;
      dflt_resp <= 1'b0;
      err_count <= '0;
      err_addr  <= '0;
      err_write <= 1'b0;
    end else begin
      case (dstate)
        D_IDLE: begin
          if (err_start) begin
            dstate    <= D_ERR1;
            dflt_rdy  <= 1'b0;
            dflt_resp <= 1'b1;
          end
        end
        D_ERR1: begin
          dstate    <= D_ERR2;
          dflt_rdy  <= 1'b1;
          dflt_resp <= 1'b1;
        end
        D_ERR2: begin
          if (err_start) begin
            dstate    <= D_ERR1;
            dflt_rdy  <= 1'b0;
            dflt_resp <= 1'b1;
          end else begin
            dstate    <= D_IDLE;
            dflt_rdy  <= 1'b1;
            dflt_resp <= 1'b0;
          end
        end
        default: begin
          dstate    <= D_IDLE;
          dflt_rdy  <= 1'b1;
          dflt_resp <= 1'b0;
        end
      endcase
      if (err_start) begin
        err_addr  <= HADDR;
        err_write <= HWRITE;
        if (!(&err_count)) err_count <= err_count + ERRCNT_W'(1);
      end
    end
  end

  // Pick the response of the slave that owns the data phase.
  always_comb begin
    slv_rdy  = 1'b1;
    slv_resp = 1'b0;
    slv_data = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel_idx == IDX_W'(i)) begin
        slv_rdy  = HREADYOUT_S[i];
        slv_resp = HRESP_S[i];
        slv_data = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Master-facing response: idle OKAY, default-slave ERROR, or the selected slave.
  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    if (dsel_valid) begin
      if (dsel_dflt) begin
        HREADY = dflt_rdy;
        HRESP  = dflt_resp;
      end else begin
        HREADY = slv_rdy;
        HRESP  = slv_resp;
        HRDATA = slv_data;
      end
    end
  end

endmodule
